gcd_arbiter: RTL
================

# gcd_arbiter

Round-robin scheduler that shares one GCD engine (datapath plus its controller) among N_REQ requesters. It captures a winning requester's operand pair and drives the engine's serial load protocol: start pulse, then A, then B on consecutive cycles. It then waits for engine done and returns the result to the winner tagged with its ID. Zero operands bypass the engine, and a watchdog recovers from a hung engine.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- TIMEOUT, 1024, max cycles in WAIT before error
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request level
- a_in  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_in  in  N_REQ*WIDTH  operand B, same packing
- grant  out  N_REQ  one-hot, one-cycle pulse: operands of requester i captured
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  $clog2(N_REQ)  requester the response belongs to
- resp_data  out  WIDTH  GCD result
- resp_err  out  1  qualifies resp_valid: engine timed out, resp_data=0
- busy  out  1  high in any state other than IDLE
- gcd_start  out  1  engine start, high for exactly one cycle per job
- gcd_data  out  WIDTH  engine serial operand bus
- gcd_done  in  1  engine done level
- gcd_result  in  WIDTH  engine result (engine A register), valid while gcd_done=1
- eng_clr  out  1  one-cycle engine clear pulse after timeout

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE, with req!=0 at an edge:
  - pick the winner: first set bit scanning from rr_ptr upward, wrapping.
  - capture a_in/b_in of the winner into regA/regB and latch id.
  - grant[id]=1 next cycle.
  - rr_ptr <= id+1 mod N_REQ.
- Bypass: if the captured regA==0 or regB==0, go IDLE->RESP directly.
  - resp_data = regA|regB, so gcd(0,0)=0.
  - grant and resp_valid are high in the same cycle.
- Otherwise IDLE->LOAD_A.
  - LOAD_A: gcd_start=1, gcd_data=regA.
  - LOAD_B: gcd_start=0, gcd_data=regB.
  - Then WAIT.
- WAIT:
  - counter increments each cycle.
  - gcd_done=1 at an edge: latch gcd_result, go to RESP with resp_err=0.
  - counter reaches TIMEOUT-1 without done: go to RESP with resp_err=1, resp_data=0, and pulse eng_clr in the RESP cycle.
- RESP: resp_valid=1 for one cycle, then IDLE. A new arbitration happens at the first edge in IDLE.
- gcd_done is ignored outside WAIT, so a stale done level from a previous job is never taken as completion.
- req is level-sensitive. A requester drops req the cycle after grant. A still-high req after its response re-enters arbitration with lowest priority.
- Operands are sampled only at the capture edge; later changes on a_in/b_in are ignored.
- gcd_data holds 0 outside LOAD_A/LOAD_B.
- No combinational path from any input to any output; all outputs are registered or decoded from the state register.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, rr_ptr=0, counter=0, all outputs 0. Applies mid-job too: no response is issued for the aborted job and grant is not repeated.
- Request seen at edge E0 gives:
  - grant plus LOAD_A in cycle E0+1
  - LOAD_B in E0+2
  - WAIT from E0+3
- Engine done sampled at edge Ek: resp_valid in cycle Ek+1. Next capture no earlier than edge Ek+2.
- Bypass: grant and resp_valid both in cycle E0+1.
- Minimum spacing between two grants: 2 cycles (bypass jobs back-to-back).
- Simultaneous requests: exactly one grant per job; other requesters wait, keeping req high.
- Timeout: resp_valid/resp_err exactly TIMEOUT cycles after entering WAIT.

## Test plan
- Single job: req[0]=1, A=143, B=78.
  - Required: grant[0] one cycle; gcd_start one cycle with gcd_data=143, next cycle gcd_data=78.
  - Required: resp_valid with resp_id=0, resp_data=13, resp_err=0.
- Round-robin: req=4'b1111 held, operand pairs (12,8), (9,6), (35,21), (17,5).
  - Required grant order: 0,1,2,3,0.
  - Required results: 4, 3, 7, 1.
- Zero bypass: A=0, B=42 gives 42 in the grant cycle; A=0, B=0 gives 0. gcd_start never asserts for either.
- Timeout: with TIMEOUT=16, hold gcd_done=0.
  - Required: resp_err=1, resp_data=0, eng_clr pulse exactly 16 cycles after WAIT entry.
  - Required: the next job completes normally.
- Reset mid-WAIT: assert rst_n=0 for one edge.
  - Required: all outputs 0, no resp_valid.
  - Required: with requests 1 and 2 pending, req[0] is granted first (rr_ptr=0).
- Stale done: hold gcd_done=1 through LOAD_A/LOAD_B. Completion must still be taken only on gcd_done sampled in WAIT.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Requester and GCD-engine signal bundle for gcd_arbiter.
// Handshake: req is a level held by a requester until its grant pulse; resp_valid is a single-cycle pulse with no backpressure.
interface gcd_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic                   resp_valid;
    logic [ID_W-1:0]        resp_id;
    logic [WIDTH-1:0]       resp_data;
    logic                   resp_err;
    logic                   busy;
    logic                   gcd_start;
    logic [WIDTH-1:0]       gcd_data;
    logic                   gcd_done;
    logic [WIDTH-1:0]       gcd_result;
    logic                   eng_clr;
    logic [2:0]             dbg_state;

    modport slave (
        input  req, a_in, b_in, gcd_done, gcd_result,
        output grant, resp_valid, resp_id, resp_data, resp_err, busy,
               gcd_start, gcd_data, eng_clr, dbg_state
    );

    modport master (
        output req, a_in, b_in, gcd_done, gcd_result,
        input  grant, resp_valid, resp_id, resp_data, resp_err, busy,
               gcd_start, gcd_data, eng_clr, dbg_state
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one serial-load GCD engine among N_REQ requesters,
// with zero-operand bypass and a WAIT watchdog.
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input logic          clk,
    input logic          rst_n,
    gcd_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             gcd_start_q, gcd_start_d;
    logic [WIDTH-1:0] gcd_data_q, gcd_data_d;
    logic             eng_clr_q, eng_clr_d;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [WIDTH-1:0] win_a, win_b;

    // Scan upward from rr_ptr with wrap; the last winner thus gets lowest priority.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
        win_a = bus.a_in[int'(win_id)*WIDTH +: WIDTH];
        win_b = bus.b_in[int'(win_id)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        reg_b_d      = reg_b_q;
        cnt_d        = cnt_q;
        grant_d      = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        gcd_start_d  = 1'b0;
        gcd_data_d   = '0;
        eng_clr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d     = win_id;
                    reg_b_d  = win_b;
                    rr_ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
                    grant_d  = N_REQ'(1) << win_id;
                    // A zero operand makes the answer the other operand; the engine is skipped.
                    if (win_a == '0 || win_b == '0) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = win_id;
                        resp_data_d  = win_a | win_b;
                    end else begin
                        state_d     = LOAD_A;
                        gcd_start_d = 1'b1;
                        gcd_data_d  = win_a;
                    end
                end
            end
            LOAD_A: begin
                state_d    = LOAD_B;
                gcd_data_d = reg_b_q;
            end
            LOAD_B: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = bus.gcd_result;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_err_d   = 1'b1;
                    eng_clr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            reg_b_q      <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            gcd_start_q  <= 1'b0;
            gcd_data_q   <= '0;
            eng_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            reg_b_q      <= reg_b_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            gcd_start_q  <= gcd_start_d;
            gcd_data_q   <= gcd_data_d;
            eng_clr_q    <= eng_clr_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.gcd_start  = gcd_start_q;
    assign bus.gcd_data   = gcd_data_q;
    assign bus.eng_clr    = eng_clr_q;
    assign bus.dbg_state  = state_q;
endmodule
